fetch_prefetch_ctrl: RTL and testbench
======================================

# fetch_prefetch_ctrl

Instruction-fetch sequencer sitting between the IF stage and the instruction memory. Owns the fetch PC, issues one outstanding request at a time to the memory over a req/ack handshake, and buffers returned words with their PC+4 in a small prefetch FIFO. It presents them to the IF/ID register, honouring pipeline freeze from the hazard unit and flushing on a taken branch. It works with the current combinational instruction memory (ack tied to req) and with any future multi-cycle memory.

## Interface
- ADDR_W, 32: fetch address / PC width.
- DEPTH, 4: prefetch FIFO entries; power of two, at least 2.
- RESET_PC, 0: fetch address after reset.

- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- freeze  in  1  hazard stall; the head entry is held, not consumed.
- branch_taken  in  1  flush request from the EX stage.
- branch_addr  in  ADDR_W  redirect target, valid with branch_taken.
- mem_req  out  1  fetch request.
- mem_addr  out  ADDR_W  word address of the request.
- mem_ack  in  1  request completed; mem_rdata is valid in this cycle.
- mem_rdata  in  32  instruction word.
- if_valid  out  1  head entry is valid.
- if_instr  out  32  head instruction; 32'h0 (NOP) when if_valid is 0.
- if_pc  out  ADDR_W  head instruction address + 4.

## Operation
- FSM states:
  - FETCH: mem_req = (count < DEPTH).
  - DISCARD: mem_req = 1 with the old address; the returning word is dropped.
- Handshake:
  - While mem_req is high, mem_addr is stable until the cycle mem_ack is high.
  - Ack may arrive in the same cycle as req (zero-wait).
  - mem_ack with mem_req low is ignored.
- Push: in FETCH, when mem_req && mem_ack && !branch_taken:
  - FIFO ← {mem_rdata, fetch_pc+4};
  - fetch_pc += 4 (wraps modulo 2^ADDR_W).
- Pop: when if_valid && !freeze && !branch_taken. Simultaneous push and pop are allowed at any count, including DEPTH-1 and DEPTH.
- Full: count == DEPTH drops mem_req in the same cycle. A pop in that cycle does not re-enable req until the next cycle.
- Branch (branch_taken = 1), which has priority over freeze, push and pop:
  - FIFO is cleared;
  - fetch_pc ← branch_addr.
  - If mem_req is high and mem_ack is low, next state is DISCARD.
  - If mem_ack is high in the same cycle, the word is dropped and the state stays FETCH.
- DISCARD:
  - On mem_ack, drop the data and go to FETCH.
  - A second branch_taken while in DISCARD only updates fetch_pc.
- branch_addr[1:0] is forced to 0 (word aligned).
- Reset:
  - count = 0, fetch_pc = RESET_PC, state = FETCH.
  - All outputs are 0 while rst is high, including mem_req and mem_addr.
  - Reset mid-transaction abandons any outstanding request. The memory must tolerate a dropped req.

## Timing
- No FIFO bypass: a word acked in cycle N is at the FIFO head in cycle N+1.
- Zero-wait memory:
  - first if_valid is in the 2nd cycle after rst deasserts;
  - sustained throughput is 1 instruction/cycle.
- Branch in cycle N:
  - if_valid = 0 in N+1;
  - the target is requested in N+1 (FETCH) or after the pending ack (DISCARD);
  - the target reaches the head one cycle after its ack.
- if_valid, if_instr and if_pc come from registered FIFO state only; there is no combinational path from mem_* to if_*.
- mem_req depends combinationally on state, count and rst only; there is no path from mem_ack.

## Structure
- Shared package `fetch_pkg`:
  - state enum {FETCH, DISCARD};
  - NOP_INSTR = 32'h0;
  - default DEPTH;
  - FIFO entry typedef {instr[31:0], pc_plus4}.
- Sub-module `fetch_fifo`: synchronous FIFO with push, pop, flush, count, full and empty. Flush has priority over push and pop.
- The top level holds the FSM, fetch_pc and the handshake logic.

## Test plan
- Reset, zero-wait memory (ack = req, 48-word program), freeze = 0 → if_pc sequence 4, 8, 12, … one per cycle from the 2nd cycle after reset; if_instr matches memory.
- freeze held 6 cycles, DEPTH = 4 → exactly 4 pushes; mem_req is low while full; the head is unchanged; after release there are no lost or duplicated PCs.
- Memory with 3-cycle ack latency, freeze = 0 → one request per 4 cycles; mem_addr is stable across the wait; if_pc increments by 4 per delivered word.
- branch_taken with branch_addr = 0x90 while a 3-cycle request to 0x20 is pending → FIFO empties next cycle; the 0x20 word is dropped; the next mem_addr is 0x90; the head if_pc is 0x94.
- branch_taken coincident with mem_ack and with freeze = 1, branch_addr = 0x94 → the acked word is not pushed; the next request is to 0x94; if_valid = 0 for one cycle.
- rst asserted mid-wait (3-cycle memory, fetch_pc = 0x40) → mem_req = 0 and if_valid = 0 during reset; after release the first mem_addr is RESET_PC = 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch prefetch block.
//   fetch_state_t  : sequencer states (FETCH normal, DISCARD drop one stale word)
//   NOP_INSTR      : instruction presented when no valid head entry exists
//   DEFAULT_DEPTH  : default prefetch FIFO depth
//   fetch_entry_t  : one FIFO entry {instr, pc_plus4}; pc_plus4 is sized for
//                    the widest supported fetch address (ADDR_W <= ENTRY_PC_W)
package fetch_pkg;

  typedef enum logic {
    FETCH   = 1'b0,
    DISCARD = 1'b1
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR     = 32'h0;
  localparam int          DEFAULT_DEPTH = 4;
  localparam int          ENTRY_PC_W    = 32;

  typedef struct packed {
    logic [31:0]           instr;
    logic [ENTRY_PC_W-1:0] pc_plus4;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_prefetch_fifo.sv
// Synchronous prefetch FIFO.
//   clk, rst      : clock, synchronous active-high reset
//   push, wdata   : write an entry (accepted when not full, or when popping)
//   pop           : consume the head entry (ignored when empty)
//   flush         : discard all entries; wins over push and pop
//   rdata         : head entry (meaningful only when !empty)
//   count         : number of stored entries, 0..DEPTH
//   full, empty   : count == DEPTH / count == 0
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = $bits(fetch_entry_t),
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  // A pop frees the slot in the same cycle, so a full FIFO may still accept.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  // NOTE: the storage array has no reset; entries are only observed through
  // count, so clearing them would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_prefetch_ctrl.sv
// Instruction-fetch sequencer with prefetch buffer.
//   clk, rst                 : clock, synchronous active-high reset
//   freeze                   : hold the head entry (hazard stall)
//   branch_taken/branch_addr : flush and redirect fetch to branch_addr
//   mem_req/mem_addr         : single outstanding request to instruction memory
//   mem_ack/mem_rdata        : completion and data of that request
//   if_valid/if_instr/if_pc  : head entry toward IF/ID (if_pc is address + 4)
module fetch_prefetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = DEFAULT_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              if_valid,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t      state;
  fetch_state_t      state_nxt;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] discard_addr;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] branch_target;

  fetch_entry_t      wentry;
  fetch_entry_t      head;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;

  assign pc_plus4      = fetch_pc + ADDR_W'(4);
  assign branch_target = {branch_addr[ADDR_W-1:2], 2'b00};

  // mem_req sees only state, FIFO occupancy and rst, never mem_ack. While a
  // request waits the FIFO cannot grow, so the request never drops mid-wait.
  // In DISCARD the stale address is held until the memory completes it.
  always_comb begin
    mem_req  = 1'b0;
    mem_addr = '0;
    if (!rst) begin
      mem_req  = (state == DISCARD) || !fifo_full;
      mem_addr = (state == DISCARD) ? discard_addr : fetch_pc;
    end
  end

  assign push = (state == FETCH) && mem_req && mem_ack && !branch_taken;
  assign pop  = !fifo_empty && !rst && !freeze && !branch_taken;

  assign wentry.instr    = mem_rdata;
  assign wentry.pc_plus4 = ENTRY_PC_W'(pc_plus4);

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wentry),
    .pop   (pop),
    .flush (branch_taken),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A branch while a request is still outstanding must let that request
  // finish before the new target can be issued; the word it returns is stale.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      FETCH:   if (branch_taken && mem_req && !mem_ack) state_nxt = DISCARD;
      DISCARD: if (mem_ack)                             state_nxt = FETCH;
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FETCH;
      fetch_pc     <= RESET_PC;
      discard_addr <= '0;
    end else begin
      state <= state_nxt;
      if (branch_taken)  fetch_pc <= branch_target;
      else if (push)     fetch_pc <= pc_plus4;
      if (state == FETCH && state_nxt == DISCARD) discard_addr <= fetch_pc;
    end
  end

  // Head outputs come from registered FIFO state only (plus the reset gate).
  assign if_valid = !rst && (fifo_count != '0);
  assign if_instr = if_valid ? head.instr : NOP_INSTR;
  assign if_pc    = if_valid ? head.pc_plus4[ADDR_W-1:0] : '0;

endmodule

// File: tb/tb_fetch_prefetch_ctrl.sv
// Directed bench for fetch_prefetch_ctrl. The memory model answers every
// address with {16'hC0DE, addr[15:0]} after a programmable wait of lat cycles.
module tb_fetch_prefetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  int lat = 0;
  int wait_cnt = 0;
  int cyc = 0;
  int errors = 0;
  int checks = 0;

  fetch_prefetch_ctrl #(
    .ADDR_W   (32),
    .DEPTH    (4),
    .RESET_PC (32'h0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .if_valid     (if_valid),
    .if_instr     (if_instr),
    .if_pc        (if_pc)
  );

  always #5 clk = ~clk;

  // Memory: ack after lat waiting cycles of a continuously held request.
  assign mem_ack   = mem_req && (wait_cnt == lat);
  assign mem_rdata = {16'hC0DE, mem_addr[15:0]};

  always @(posedge clk) begin
    if (!mem_req || mem_ack) wait_cnt <= 0;
    else                     wait_cnt <= wait_cnt + 1;
  end

  function automatic logic [31:0] word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int n);
    while (cyc < n) step();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_req"},   mem_req,  0);
    check({tag, "_addr"},  mem_addr, 0);
    check({tag, "_valid"}, if_valid, 0);
    check({tag, "_instr"}, if_instr, 0);
    check({tag, "_pc"},    if_pc,    0);
  endtask

  // Two reset cycles, then release; the release cycle becomes cycle 0.
  task automatic do_reset(input int l);
    rst = 1'b1;
    lat = l;
    freeze = 1'b0;
    branch_taken = 1'b0;
    #1;
    check_idle("rst_a");
    step();
    check_idle("rst_b");
    step();
    rst = 1'b0;
    cyc = 0;
    #1;
  endtask

  initial begin
    int pushes;

    // Zero-wait memory, 48-word program, one instruction per cycle.
    do_reset(0);
    check("zw_c0_valid", if_valid, 0);
    check("zw_c0_req",   mem_req,  1);
    check("zw_c0_ack",   mem_ack,  1);
    for (int k = 1; k <= 48; k++) begin
      step();
      check("zw_valid", if_valid, 1);
      check("zw_pc",    if_pc,    32'(4 * k));
      check("zw_instr", if_instr, word(32'(4 * k - 4)));
    end

    // Freeze for 6 cycles from the first fetch: four pushes fill the FIFO.
    do_reset(0);
    freeze = 1'b1;
    pushes = 0;
    for (int k = 0; k <= 5; k++) begin
      goto(k);
      if (mem_req && mem_ack) pushes++;
      if (k >= 1) check("frz_head", if_pc, 32'h4);
      if (k >= 4) check("frz_req_low", mem_req, 0);
    end
    check("frz_pushes", pushes, 4);
    step();
    freeze = 1'b0;
    for (int k = 6; k <= 15; k++) begin
      goto(k);
      check("frz_seq_valid", if_valid, 1);
      check("frz_seq_pc",    if_pc,    32'(4 * (k - 5)));
    end

    // 3-cycle memory: one request every 4 cycles, address stable while waiting.
    do_reset(3);
    for (int k = 0; k <= 3; k++) begin
      goto(k);
      check("lat_req",  mem_req,  1);
      check("lat_addr", mem_addr, 0);
      check("lat_ack",  mem_ack,  (k == 3) ? 1 : 0);
    end
    goto(4);
    check("lat_c4_valid", if_valid, 1);
    check("lat_c4_pc",    if_pc,    32'h4);
    check("lat_c4_addr",  mem_addr, 32'h4);
    goto(5);
    check("lat_c5_valid", if_valid, 0);
    goto(7);
    check("lat_c7_addr",  mem_addr, 32'h4);
    goto(8);
    check("lat_c8_pc",    if_pc,    32'h8);
    check("lat_c8_addr",  mem_addr, 32'h8);
    goto(12);
    check("lat_c12_pc",   if_pc,    32'hC);

    // Branch to 0x90 while the 0x20 request is pending; head is held by freeze.
    goto(30);
    freeze = 1'b1;
    goto(33);
    check("br_pre_valid", if_valid, 1);
    check("br_pre_pc",    if_pc,    32'h20);
    check("br_pre_addr",  mem_addr, 32'h20);
    check("br_pre_ack",   mem_ack,  0);
    branch_taken = 1'b1;
    branch_addr  = 32'h90;
    step();
    branch_taken = 1'b0;
    freeze = 1'b0;
    check("br_flush_valid", if_valid, 0);
    check("br_hold_addr",   mem_addr, 32'h20);
    check("br_hold_req",    mem_req,  1);
    goto(35);
    check("br_stale_ack",   mem_ack,  1);
    goto(36);
    check("br_new_addr",    mem_addr, 32'h90);
    check("br_dropped",     if_valid, 0);
    goto(39);
    check("br_c39_valid",   if_valid, 0);
    goto(40);
    check("br_tgt_valid",   if_valid, 1);
    check("br_tgt_pc",      if_pc,    32'h94);
    check("br_tgt_instr",   if_instr, word(32'h90));

    // Branch coincident with ack and freeze; unaligned target is word-aligned.
    do_reset(0);
    goto(5);
    check("bc_pre_pc",  if_pc,   32'h14);
    check("bc_pre_ack", mem_ack, 1);
    freeze = 1'b1;
    branch_taken = 1'b1;
    branch_addr  = 32'h97;
    step();
    branch_taken = 1'b0;
    freeze = 1'b0;
    check("bc_gap_valid", if_valid, 0);
    check("bc_req",       mem_req,  1);
    check("bc_addr",      mem_addr, 32'h94);
    step();
    check("bc_tgt_valid", if_valid, 1);
    check("bc_tgt_pc",    if_pc,    32'h98);
    check("bc_tgt_instr", if_instr, word(32'h94));
    step();
    check("bc_next_pc",   if_pc,    32'h9C);

    // Reset while the 3-cycle request to 0x40 is waiting.
    do_reset(3);
    goto(65);
    check("rm_pre_addr", mem_addr, 32'h40);
    check("rm_pre_ack",  mem_ack,  0);
    rst = 1'b1;
    #1;
    check("rm_req",   mem_req,  0);
    check("rm_valid", if_valid, 0);
    check("rm_addr",  mem_addr, 0);
    step();
    check("rm_req2",   mem_req,  0);
    check("rm_valid2", if_valid, 0);
    rst = 1'b0;
    cyc = 0;
    #1;
    check("rm_rel_req",  mem_req,  1);
    check("rm_rel_addr", mem_addr, 32'h0);
    goto(3);
    check("rm_c3_valid", if_valid, 0);
    goto(4);
    check("rm_c4_pc",    if_pc,    32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
